// File: rtl/led_blink_sequencer.sv
// led_blink_sequencer: clock-enable step scheduler driving four LED blink patterns
module led_blink_sequencer #(
  parameter int TICK_DIV = 25_000_000,
  parameter int NUM_LEDS = 5
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic [1:0]          rate_sel,
  input  logic                next_req,
  input  logic                pause_req,
  output logic                tick,
  output logic [NUM_LEDS-1:0] led,
  output logic [1:0]          pattern_idx,
  output logic                paused
);
  localparam int PW = $clog2(TICK_DIV * 8 + 1);
  localparam int LW = NUM_LEDS + 1;
  typedef enum logic {RUN, PAUSE} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] cnt, period_r, period_sel;
  logic [NUM_LEDS-1:0] s, s_adv, s_nxt, b, led_nxt;
  logic [LW-1:0] s_inc, len;
  logic [1:0] p, p_adv;
  logic pending, wrap, adv;
  assign period_sel = PW'(TICK_DIV) << rate_sel;
  assign pattern_idx = p;
  assign paused = state == PAUSE;
  always_ff @(posedge clk_in) begin
    if (rst) state <= RUN;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = pause_req ? (state == RUN ? PAUSE : RUN) : state;
    wrap = state == RUN && cnt == period_r - PW'(1);
    adv = pending | next_req;
    p_adv = adv ? p + 2'd1 : p;
    s_adv = adv ? '0 : s;
    len = p_adv == 2'd0 ? LW'(2) : p_adv == 2'd1 ? LW'(NUM_LEDS) : p_adv == 2'd2 ? LW'(2 * NUM_LEDS - 2) : LW'(1) << NUM_LEDS;
    s_inc = {1'b0, s_adv} + LW'(1);
    s_nxt = s_inc == len ? '0 : s_inc[NUM_LEDS-1:0];
    b = s_adv < NUM_LEDS'(NUM_LEDS) ? s_adv : NUM_LEDS'(2 * NUM_LEDS - 2) - s_adv;
    led_nxt = p_adv == 2'd0 ? (s_adv == '0 ? '1 : '0)
            : p_adv == 2'd1 ? NUM_LEDS'(1) << s_adv
            : p_adv == 2'd2 ? NUM_LEDS'(1) << b
            : s_adv;
  end
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt <= '0;
      period_r <= period_sel;
      p <= '0;
      s <= '0;
      pending <= 1'b0;
      tick <= 1'b0;
      led <= '0;
    end else begin
      tick <= wrap;
      if (state == RUN) cnt <= wrap ? '0 : cnt + PW'(1);
      if (wrap) begin
        period_r <= period_sel;
        p <= p_adv;
        s <= s_nxt;
        led <= led_nxt;
        pending <= 1'b0;
      end else if (next_req) pending <= 1'b1;
    end
  end
endmodule

// File: tb/tb_led_blink_sequencer.sv
// tb_led_blink_sequencer: directed and randomized checks against a sequence-table model
module tb_led_blink_sequencer;
  localparam int TD = 3;
  localparam int N = 5;
  logic clk_in = 1'b0;
  logic rst = 1'b1;
  logic next_req = 1'b0;
  logic pause_req = 1'b0;
  logic [1:0] rate_sel = 2'd0;
  logic tick;
  logic [N-1:0] led;
  logic [1:0] pattern_idx;
  logic paused;
  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  logic [N-1:0] seq [4][32];
  int len [4];
  int m_rem = 0;
  int m_pat = 0;
  int m_pos = 0;
  logic m_pend = 1'b0;
  logic m_paused = 1'b0;
  logic m_tick = 1'b0;
  logic [N-1:0] m_led = '0;

  led_blink_sequencer #(.TICK_DIV(TD), .NUM_LEDS(N)) dut (
    .clk_in(clk_in),
    .rst(rst),
    .rate_sel(rate_sel),
    .next_req(next_req),
    .pause_req(pause_req),
    .tick(tick),
    .led(led),
    .pattern_idx(pattern_idx),
    .paused(paused)
  );

  always #5 clk_in = ~clk_in;

  function automatic void build_tables();
    int k;
    len[0] = 2;
    seq[0][0] = '1;
    seq[0][1] = '0;
    len[1] = N;
    for (int i = 0; i < N; i++) seq[1][i] = N'(1) << i;
    len[2] = 2 * N - 2;
    k = 0;
    for (int i = 0; i < N; i++) begin
      seq[2][k] = N'(1) << i;
      k++;
    end
    for (int i = N - 2; i >= 1; i--) begin
      seq[2][k] = N'(1) << i;
      k++;
    end
    len[3] = 1 << N;
    for (int i = 0; i < (1 << N); i++) seq[3][i] = N'(i);
  endfunction

  // Advances the model by one clock using the inputs the DUT is about to sample.
  function automatic void model_update();
    if (rst) begin
      m_rem = TD << rate_sel;
      m_pat = 0;
      m_pos = 0;
      m_pend = 1'b0;
      m_paused = 1'b0;
      m_tick = 1'b0;
      m_led = '0;
    end else begin
      m_tick = 1'b0;
      if (!m_paused) begin
        if (m_rem == 1) begin
          m_tick = 1'b1;
          m_rem = TD << rate_sel;
          if (m_pend || next_req) begin
            m_pat = (m_pat + 1) % 4;
            m_pos = 0;
          end
          m_led = seq[m_pat][m_pos];
          m_pos = (m_pos + 1) % len[m_pat];
          m_pend = 1'b0;
        end else m_rem--;
      end
      if (next_req && !m_tick) m_pend = 1'b1;
      if (pause_req) m_paused = !m_paused;
    end
  endfunction

  function automatic logic [N+3:0] obs();
    return {tick, led, pattern_idx, paused};
  endfunction

  function automatic logic [N+3:0] mdl();
    return {m_tick, m_led, 2'(m_pat), m_paused};
  endfunction

  task automatic step(input logic nr, input logic pr);
    next_req = nr;
    pause_req = pr;
    model_update();
    @(posedge clk_in);
    @(negedge clk_in);
    next_req = 1'b0;
    pause_req = 1'b0;
    edge_n++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rate_sel = 2'd0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst = 1'b0;
    edge_n = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rate_sel = 2'd0;
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    checks++;
    if (obs() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b", obs(), {(N+4){1'b0}});
    end
    checks++;
    if (obs() !== mdl()) begin
      errors++;
      $display("FAIL reset_model: got %b want %b", obs(), mdl());
    end
    rst = 1'b0;
    edge_n = 0;
  endtask

  task automatic test_blink();
    logic [N-1:0] want [3] = '{5'b11111, 5'b00000, 5'b11111};
    for (int e = 1; e <= 9; e++) begin
      step(1'b0, 1'b0);
      checks++;
      if (obs() !== mdl()) begin
        errors++;
        $display("FAIL blink_model edge %0d: got %b want %b", edge_n, obs(), mdl());
      end
      if (edge_n % 3 == 0) begin
        checks++;
        if (obs() !== {1'b1, want[edge_n / 3 - 1], 2'd0, 1'b0}) begin
          errors++;
          $display("FAIL blink_tick edge %0d: got %b want %b", edge_n, obs(), {1'b1, want[edge_n / 3 - 1], 2'd0, 1'b0});
        end
      end
    end
  endtask

  task automatic test_walk();
    logic [N-1:0] want [6] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    do_reset();
    for (int e = 1; e <= 21; e++) begin
      step(e == 4, 1'b0);
      checks++;
      if (obs() !== mdl()) begin
        errors++;
        $display("FAIL walk_model edge %0d: got %b want %b", edge_n, obs(), mdl());
      end
      if (edge_n >= 6 && edge_n % 3 == 0) begin
        checks++;
        if ({tick, led, pattern_idx} !== {1'b1, want[(edge_n - 6) / 3], 2'd1}) begin
          errors++;
          $display("FAIL walk_tick edge %0d: got %b want %b", edge_n, {tick, led, pattern_idx}, {1'b1, want[(edge_n - 6) / 3], 2'd1});
        end
      end
    end
  endtask

  task automatic test_bounce();
    logic [N-1:0] want [9] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
    for (int e = 22; e <= 48; e++) begin
      step(e == 22 || e == 23, 1'b0);
      checks++;
      if (obs() !== mdl()) begin
        errors++;
        $display("FAIL bounce_model edge %0d: got %b want %b", edge_n, obs(), mdl());
      end
      if (edge_n >= 24 && edge_n % 3 == 0) begin
        checks++;
        if ({tick, led, pattern_idx} !== {1'b1, want[(edge_n - 24) / 3], 2'd2}) begin
          errors++;
          $display("FAIL bounce_tick edge %0d: got %b want %b", edge_n, {tick, led, pattern_idx}, {1'b1, want[(edge_n - 24) / 3], 2'd2});
        end
      end
    end
  endtask

  task automatic test_rate();
    logic want_t;
    do_reset();
    for (int e = 1; e <= 30; e++) begin
      if (e == 4) rate_sel = 2'd2;
      step(1'b0, 1'b0);
      want_t = (e == 3 || e == 6 || e == 18 || e == 30);
      checks++;
      if (tick !== want_t || obs() !== mdl()) begin
        errors++;
        $display("FAIL rate_tick edge %0d: got %b want tick %b model %b", edge_n, obs(), want_t, mdl());
      end
    end
    rate_sel = 2'd0;
  endtask

  task automatic test_pause();
    do_reset();
    for (int e = 1; e <= 27; e++) begin
      step(e == 10, e == 4 || e == 25);
      checks++;
      if (obs() !== mdl()) begin
        errors++;
        $display("FAIL pause_model edge %0d: got %b want %b", edge_n, obs(), mdl());
      end
      if (e >= 4 && e <= 24) begin
        checks++;
        if ({tick, led, paused} !== {1'b0, 5'b11111, 1'b1}) begin
          errors++;
          $display("FAIL pause_hold edge %0d: got %b want %b", edge_n, {tick, led, paused}, {1'b0, 5'b11111, 1'b1});
        end
      end
      if (e == 25 || e == 26) begin
        checks++;
        if ({tick, paused} !== 2'b00) begin
          errors++;
          $display("FAIL pause_resume edge %0d: got %b want %b", edge_n, {tick, paused}, 2'b00);
        end
      end
    end
    checks++;
    if (obs() !== {1'b1, 5'b00001, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL pause_first_tick: got %b want %b", obs(), {1'b1, 5'b00001, 2'd1, 1'b0});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int e = 1; e <= 25; e++) begin
      step(e == 1 || e == 4 || e == 7 || e == 25, 1'b0);
      if (e == 24) begin
        checks++;
        if ({tick, led, pattern_idx} !== {1'b1, 5'b00101, 2'd3}) begin
          errors++;
          $display("FAIL count_reach edge %0d: got %b want %b", edge_n, {tick, led, pattern_idx}, {1'b1, 5'b00101, 2'd3});
        end
      end
    end
    rst = 1'b1;
    step(1'b0, 1'b0);
    checks++;
    if (obs() !== '0 || obs() !== mdl()) begin
      errors++;
      $display("FAIL reset_mid: got %b want %b", obs(), {(N+4){1'b0}});
    end
    rst = 1'b0;
    edge_n = 0;
    for (int e = 1; e <= 3; e++) step(1'b0, 1'b0);
    checks++;
    if (obs() !== {1'b1, 5'b11111, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_pending_dropped: got %b want %b", obs(), {1'b1, 5'b11111, 2'd0, 1'b0});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rate_sel = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 499) == 0);
      step($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0);
      checks++;
      if (obs() !== mdl()) begin
        errors++;
        $display("FAIL random_model cycle %0d: got %b want %b", i, obs(), mdl());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    build_tables();
    test_reset();
    test_blink();
    test_walk();
    test_bounce();
    test_rate();
    test_pause();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_blink_sequencer.md
# led_blink_sequencer

Tick scheduler and pattern sequencer for the evaluation-kit user LEDs. It divides the board clock down to a programmable step rate using a clock-enable strobe rather than a derived clock. On each step it drives the LEDs through one of four blink patterns. It sits between the debounced push-button logic (pulse requests) and the LED pins, and replaces free-running divided clocks as the LED timing source.

## Interface
- TICK_DIV, 25_000_000, base step interval in clk_in cycles (0.5 s at 50 MHz); must be ≥ 2
- NUM_LEDS, 5, LED count; legal range 2..8
- clk_in  input  1  system clock, all logic on rising edge
- rst  input  1  reset: synchronous, active-high
- rate_sel  input  2  interval select; step interval = TICK_DIV << rate_sel
- next_req  input  1  single-cycle pulse: advance to next pattern
- pause_req  input  1  single-cycle pulse: toggle RUN/PAUSE
- tick  output  1  one-cycle strobe per step
- led  output  NUM_LEDS  LED drive, 1 = on
- pattern_idx  output  2  current pattern number
- paused  output  1  high in PAUSE state

## Operation
- State registers:
  - state ∈ {RUN, PAUSE}
  - prescaler cnt, wide enough for (TICK_DIV << 3) − 1
  - period_r
  - pattern p (0..3)
  - step s
  - pending flag
- Reset values:
  - state = RUN, cnt = 0, period_r = TICK_DIV << rate_sel, p = 0, s = 0, pending = 0
  - outputs tick = 0, led = 0, pattern_idx = 0, paused = 0
- RUN, each cycle:
  - If cnt == period_r − 1: wrap event; cnt ← 0; period_r ← TICK_DIV << rate_sel.
  - Otherwise cnt ← cnt + 1.
- PAUSE: cnt, period_r, p, s and led hold; no wrap, tick = 0.
- pause_req toggles state. If pause_req coincides with a wrap in RUN, the wrap completes normally, then the block enters PAUSE.
- next_req sets pending in either state. Multiple requests before a wrap collapse into one advance.
- Wrap event, with adv = pending | next_req:
  - If adv: p' = (p + 1) mod 4, s' = 0; otherwise p' = p, s' = s.
  - led ← f(p', s'); p ← p'; s ← (s' + 1) mod len(p'); pending ← 0; tick ← 1.
- Patterns, with N = NUM_LEDS:
  - p = 0, blink: len 2; s = 0 → all ones, s = 1 → all zeros.
  - p = 1, walk: len N; led = 1 << s.
  - p = 2, bounce: len 2N − 2; s < N → 1 << s, else 1 << (2N − 2 − s).
  - p = 3, count: len 2^N; led = s.
- Width rules:
  - s is wide enough for 2^N − 1.
  - The wrap comparison uses period_r at full width; no truncation of TICK_DIV << 3.
- pattern_idx = p and paused = (state == PAUSE), both registered.
- rst at any time, including mid-interval, in PAUSE, or with pending set: all registers return to reset values on that edge; pending requests are discarded.
- next_req and pause_req in the same cycle: both take effect.

## Timing
- All outputs are registered and change only on clk_in rising edges.
- Edge 1 is the first edge sampling rst = 0. The first tick is visible after edge period_r, then every period_r edges while in RUN.
- tick lasts exactly one cycle. led, pattern_idx and s update in the same cycle tick rises.
- A rate_sel change never shortens or lengthens the interval in progress. It applies from the next interval.
- Pause/resume preserves cnt. After resume, the next tick arrives after the remaining period_r − cnt cycles.
- Latency from next_req to a visible pattern change: 0 if the request lands on a wrap cycle, otherwise up to period_r − 1 cycles.

## Test plan
All scenarios use TICK_DIV = 3, NUM_LEDS = 5.
- Release rst with rate_sel = 0: tick after edges 3, 6, 9; led = 11111, 00000, 11111; pattern_idx = 0; paused = 0 throughout.
- next_req pulse at edge 4: the tick at edge 6 shows pattern_idx = 1, led = 00001. Following ticks show 00010, 00100, 01000, 10000, 00001.
- Two next_req pulses within one interval from pattern 1: advance to pattern 2 only. Ticks show 00001, 00010, 00100, 01000, 10000, 01000, 00100, 00010, 00001.
- rate_sel changed 0 → 2 at edge 4: the tick at edge 6 is unchanged; subsequent ticks arrive every 12 cycles (18, 30, ...).
- pause_req at edge 4:
  - paused = 1; no tick for 20 cycles; led held.
  - Pulse next_req during the pause.
  - A second pause_req at edge 25 resumes. The next tick arrives 2 cycles later with pattern_idx advanced and step 0 shown.
- Reach pattern 3 with led = 00101, set pending, then assert rst for one cycle: the next cycle shows led = 00000, tick = 0, pattern_idx = 0, paused = 0. The first post-reset tick shows 11111 (pending discarded).
